// File: rtl/ap1000_bp_reset_sequencer.sv
// Staged reset generator: pulses the DCM reset, qualifies the DCM locks and releases domain resets in order.
// Define AP1000_RST_SEQ_LOCK_TIMEOUT_EN to re-pulse the DCMs when lock acquisition takes too long.
module ap1000_bp_reset_sequencer #(
  parameter int unsigned NUM_DCMS           = 3,
  parameter int unsigned NUM_DOMAINS        = 3,
  parameter int unsigned DCM_RST_CYCLES     = 4,
  parameter int unsigned LOCK_STABLE_CYCLES = 8,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned LOCK_TIMEOUT       = 1024
) (
  input  logic                   plb_clk,
  input  logic                   async_fpga_rst,
  input  logic [NUM_DCMS-1:0]    dcm_locked,
  input  logic                   sw_rst_req,
  output logic                   dcm_rst,
  output logic [NUM_DOMAINS-1:0] RST,
  output logic                   seq_done,
  output logic [7:0]             lock_lost_cnt
);

  localparam int unsigned STG_MAX = NUM_DOMAINS * STAGE_GAP;
  localparam int unsigned STG_W   = $clog2(STG_MAX + 1);
  localparam int unsigned CNT_MAX = (DCM_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    DCM_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_DCM_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_SW_HOLD   = 3'd5
  } state_t;

  state_t               state;
  logic [NUM_DCMS-1:0]  lock_meta;
  logic [NUM_DCMS-1:0]  lock_s;
  logic [CNT_W-1:0]     cnt;
  logic [STG_W-1:0]     stage;
  logic [STG_W-1:0]     stage_inc_c;
  logic                 all_locked_c;
  logic                 lock_loss_c;
  logic                 timeout_c;

  assign all_locked_c = &lock_s;
  assign stage_inc_c  = stage + STG_W'(1);
  assign lock_loss_c  = !all_locked_c &&
                        (state == S_RELEASE || state == S_RUN || state == S_SW_HOLD);

`ifdef AP1000_RST_SEQ_LOCK_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;

  // Spans STABLE->WAIT_LOCK bounces; cleared only outside lock acquisition
  always_ff @(posedge plb_clk or posedge async_fpga_rst) begin
    if (async_fpga_rst) begin
      tmr <= '0;
    end else if ((state == S_WAIT_LOCK || state == S_STABLE) && !timeout_c) begin
      tmr <= tmr + TMR_W'(1);
    end else begin
      tmr <= '0;
    end
  end

  assign timeout_c = (state == S_WAIT_LOCK || state == S_STABLE) &&
                     (tmr == TMR_W'(LOCK_TIMEOUT - 1));
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^32'(LOCK_TIMEOUT);
  assign timeout_c           = 1'b0;
`endif

  // Lock synchroniser, sequencing FSM and registered outputs
  always_ff @(posedge plb_clk or posedge async_fpga_rst) begin
    if (async_fpga_rst) begin
      lock_meta     <= '0;
      lock_s        <= '0;
      state         <= S_DCM_RST;
      cnt           <= '0;
      stage         <= '0;
      dcm_rst       <= 1'b1;
      RST           <= '1;
      seq_done      <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      lock_meta <= dcm_locked;
      lock_s    <= lock_meta;

      if (lock_loss_c) begin
        state    <= S_DCM_RST;
        cnt      <= '0;
        stage    <= '0;
        dcm_rst  <= 1'b1;
        RST      <= '1;
        seq_done <= 1'b0;
        if (lock_lost_cnt != 8'hFF) begin
          lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
      end else if (timeout_c) begin
        // Lock took too long: re-pulse the DCMs without counting a lock loss
        state   <= S_DCM_RST;
        cnt     <= '0;
        dcm_rst <= 1'b1;
        RST     <= '1;
      end else begin
        case (state)
          S_DCM_RST: begin
            dcm_rst  <= 1'b1;
            RST      <= '1;
            seq_done <= 1'b0;
            if (cnt == CNT_W'(DCM_RST_CYCLES - 1)) begin
              state   <= S_WAIT_LOCK;
              cnt     <= '0;
              dcm_rst <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_WAIT_LOCK: begin
            dcm_rst <= 1'b0;
            if (all_locked_c) begin
              state <= S_STABLE;
              cnt   <= '0;
            end
          end

          S_STABLE: begin
            if (!all_locked_c) begin
              state <= S_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
              state <= S_RELEASE;
              cnt   <= '0;
              stage <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_RELEASE: begin
            if (sw_rst_req) begin
              state    <= S_SW_HOLD;
              RST      <= '1;
              seq_done <= 1'b0;
            end else begin
              stage <= stage_inc_c;
              for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                if (stage_inc_c == STG_W'((i + 1) * STAGE_GAP)) begin
                  RST[i] <= 1'b0;
                end
              end
              if (stage_inc_c == STG_W'(STG_MAX)) begin
                state    <= S_RUN;
                seq_done <= 1'b1;
              end
            end
          end

          S_RUN: begin
            if (sw_rst_req) begin
              state    <= S_SW_HOLD;
              RST      <= '1;
              seq_done <= 1'b0;
            end
          end

          S_SW_HOLD: begin
            dcm_rst <= 1'b0;
            RST     <= '1;
            if (!sw_rst_req) begin
              state <= S_RELEASE;
              stage <= '0;
            end
          end

          default: begin
            state    <= S_DCM_RST;
            cnt      <= '0;
            stage    <= '0;
            dcm_rst  <= 1'b1;
            RST      <= '1;
            seq_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ap1000_bp_reset_sequencer.sv
// Directed bench for ap1000_bp_reset_sequencer; edge numbers count plb_clk rising edges from a marked point.
// Honors AP1000_RST_SEQ_LOCK_TIMEOUT_EN for the timeout scenario.
module tb_ap1000_bp_reset_sequencer;

  logic       plb_clk;
  logic       async_fpga_rst;
  logic [2:0] dcm_locked;
  logic       sw_rst_req;
  logic       dcm_rst;
  logic [2:0] RST;
  logic       seq_done;
  logic [7:0] lock_lost_cnt;

  int n_cmp  = 0;
  int n_err  = 0;
  int ecount = 0;

  ap1000_bp_reset_sequencer #(
    .NUM_DCMS(3), .NUM_DOMAINS(3), .DCM_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8), .STAGE_GAP(16), .LOCK_TIMEOUT(64)
  ) dut (
    .plb_clk(plb_clk), .async_fpga_rst(async_fpga_rst), .dcm_locked(dcm_locked),
    .sw_rst_req(sw_rst_req), .dcm_rst(dcm_rst), .RST(RST), .seq_done(seq_done),
    .lock_lost_cnt(lock_lost_cnt)
  );

  initial plb_clk = 1'b0;
  always #5 plb_clk = ~plb_clk;

  task automatic tick();
    @(posedge plb_clk);
    #1;
    ecount++;
  endtask

  task automatic to_edge(input int e);
    while (ecount < e) tick();
  endtask

  task automatic apply_reset(input logic [2:0] locks);
    async_fpga_rst = 1'b1;
    dcm_locked     = locks;
    sw_rst_req     = 1'b0;
    repeat (5) tick();
    async_fpga_rst = 1'b0;
    ecount         = 0;
  endtask

  task automatic test_reset();
    async_fpga_rst = 1'b0; dcm_locked = 3'b000; sw_rst_req = 1'b0;
    #3 async_fpga_rst = 1'b1;
    #1;
    n_cmp++; if (dcm_rst !== 1'b1) begin n_err++; $display("FAIL reset_dcm_rst: got %b want 1", dcm_rst); end
    n_cmp++; if (RST !== 3'b111) begin n_err++; $display("FAIL reset_RST: got %b want 111", RST); end
    n_cmp++; if (seq_done !== 1'b0) begin n_err++; $display("FAIL reset_seq_done: got %b want 0", seq_done); end
    n_cmp++; if (lock_lost_cnt !== 8'd0) begin n_err++; $display("FAIL reset_lost_cnt: got %0d want 0", lock_lost_cnt); end
  endtask

  task automatic test_power_up();
    apply_reset(3'b000);
    to_edge(3);
    n_cmp++; if (dcm_rst !== 1'b1) begin n_err++; $display("FAIL pu_dcm_rst_e3: got %b want 1", dcm_rst); end
    to_edge(4);
    n_cmp++; if (dcm_rst !== 1'b0) begin n_err++; $display("FAIL pu_dcm_rst_e4: got %b want 0", dcm_rst); end
    to_edge(10);
    dcm_locked = 3'b111;
    to_edge(36);
    n_cmp++; if (RST !== 3'b111) begin n_err++; $display("FAIL pu_RST_e36: got %b want 111", RST); end
    to_edge(37);
    n_cmp++; if (RST !== 3'b110) begin n_err++; $display("FAIL pu_RST_e37: got %b want 110", RST); end
    to_edge(53);
    n_cmp++; if (RST !== 3'b100) begin n_err++; $display("FAIL pu_RST_e53: got %b want 100", RST); end
    to_edge(68);
    n_cmp++; if (RST !== 3'b100 || seq_done !== 1'b0) begin n_err++; $display("FAIL pu_e68: got RST=%b done=%b want 100/0", RST, seq_done); end
    to_edge(69);
    n_cmp++; if (RST !== 3'b000 || seq_done !== 1'b1) begin n_err++; $display("FAIL pu_e69: got RST=%b done=%b want 000/1", RST, seq_done); end
  endtask

  task automatic test_lock_loss();
    ecount = 0;
    dcm_locked = 3'b101;
    to_edge(2);
    n_cmp++; if (RST !== 3'b000 || seq_done !== 1'b1) begin n_err++; $display("FAIL ll_e2: got RST=%b done=%b want 000/1", RST, seq_done); end
    to_edge(3);
    n_cmp++; if (RST !== 3'b111 || seq_done !== 1'b0) begin n_err++; $display("FAIL ll_e3: got RST=%b done=%b want 111/0", RST, seq_done); end
    n_cmp++; if (lock_lost_cnt !== 8'd1) begin n_err++; $display("FAIL ll_cnt1: got %0d want 1", lock_lost_cnt); end
    dcm_locked = 3'b111;
    to_edge(6);
    n_cmp++; if (dcm_rst !== 1'b1) begin n_err++; $display("FAIL ll_dcm_rst_e6: got %b want 1", dcm_rst); end
    to_edge(7);
    n_cmp++; if (dcm_rst !== 1'b0) begin n_err++; $display("FAIL ll_dcm_rst_e7: got %b want 0", dcm_rst); end
    to_edge(64);
    n_cmp++; if (RST !== 3'b000 || seq_done !== 1'b1) begin n_err++; $display("FAIL ll_rerun: got RST=%b done=%b want 000/1", RST, seq_done); end
    // Each pass drops lock in RUN/RELEASE and lets the sequence re-enter RELEASE
    for (int k = 0; k < 254; k++) begin
      dcm_locked = 3'b000; repeat (3) tick();
      dcm_locked = 3'b111; repeat (20) tick();
    end
    n_cmp++; if (lock_lost_cnt !== 8'd255) begin n_err++; $display("FAIL ll_cnt255: got %0d want 255", lock_lost_cnt); end
    dcm_locked = 3'b000; repeat (3) tick();
    n_cmp++; if (RST !== 3'b111 || lock_lost_cnt !== 8'd255) begin n_err++; $display("FAIL ll_sat: got RST=%b cnt=%0d want 111/255", RST, lock_lost_cnt); end
    dcm_locked = 3'b111; repeat (20) tick();
    repeat (41) tick();
    n_cmp++; if (RST !== 3'b000 || seq_done !== 1'b1) begin n_err++; $display("FAIL ll_final_run: got RST=%b done=%b want 000/1", RST, seq_done); end
  endtask

  task automatic test_soft_reset();
    ecount = 0;
    sw_rst_req = 1'b1;
    to_edge(1);
    n_cmp++; if (RST !== 3'b111 || seq_done !== 1'b0 || dcm_rst !== 1'b0) begin n_err++; $display("FAIL sw_e1: got RST=%b done=%b dcm=%b want 111/0/0", RST, seq_done, dcm_rst); end
    to_edge(10);
    sw_rst_req = 1'b0;
    n_cmp++; if (RST !== 3'b111 || dcm_rst !== 1'b0) begin n_err++; $display("FAIL sw_hold: got RST=%b dcm=%b want 111/0", RST, dcm_rst); end
    to_edge(26);
    n_cmp++; if (RST !== 3'b111) begin n_err++; $display("FAIL sw_e26: got %b want 111", RST); end
    to_edge(27);
    n_cmp++; if (RST !== 3'b110) begin n_err++; $display("FAIL sw_e27: got %b want 110", RST); end
    to_edge(43);
    n_cmp++; if (RST !== 3'b100) begin n_err++; $display("FAIL sw_e43: got %b want 100", RST); end
    to_edge(59);
    n_cmp++; if (RST !== 3'b000 || seq_done !== 1'b1 || lock_lost_cnt !== 8'd255) begin n_err++; $display("FAIL sw_e59: got RST=%b done=%b cnt=%0d want 000/1/255", RST, seq_done, lock_lost_cnt); end
  endtask

  task automatic test_mid_release_reset();
    ecount = 0;
    sw_rst_req = 1'b1;
    to_edge(1);
    sw_rst_req = 1'b0;
    to_edge(20);
    n_cmp++; if (RST !== 3'b110) begin n_err++; $display("FAIL mr_pre: got %b want 110", RST); end
    #2 async_fpga_rst = 1'b1;
    #1;
    n_cmp++; if (dcm_rst !== 1'b1 || RST !== 3'b111 || seq_done !== 1'b0 || lock_lost_cnt !== 8'd0) begin
      n_err++; $display("FAIL mr_async: got dcm=%b RST=%b done=%b cnt=%0d want 1/111/0/0", dcm_rst, RST, seq_done, lock_lost_cnt);
    end
  endtask

  task automatic test_glitch_lock();
    apply_reset(3'b000);
    to_edge(10); dcm_locked = 3'b111;
    to_edge(16); dcm_locked = 3'b110;
    to_edge(17); dcm_locked = 3'b111;
    to_edge(37);
    n_cmp++; if (RST !== 3'b111) begin n_err++; $display("FAIL gl_e37: got %b want 111", RST); end
    to_edge(43);
    n_cmp++; if (RST !== 3'b111) begin n_err++; $display("FAIL gl_e43: got %b want 111", RST); end
    to_edge(44);
    n_cmp++; if (RST !== 3'b110) begin n_err++; $display("FAIL gl_e44: got %b want 110", RST); end
  endtask

  task automatic test_timeout();
    apply_reset(3'b000);
`ifdef AP1000_RST_SEQ_LOCK_TIMEOUT_EN
    to_edge(67);
    n_cmp++; if (dcm_rst !== 1'b0) begin n_err++; $display("FAIL to_e67: got %b want 0", dcm_rst); end
    to_edge(68);
    n_cmp++; if (dcm_rst !== 1'b1) begin n_err++; $display("FAIL to_e68: got %b want 1", dcm_rst); end
    to_edge(71);
    n_cmp++; if (dcm_rst !== 1'b1) begin n_err++; $display("FAIL to_e71: got %b want 1", dcm_rst); end
    to_edge(72);
    n_cmp++; if (dcm_rst !== 1'b0) begin n_err++; $display("FAIL to_e72: got %b want 0", dcm_rst); end
    to_edge(135);
    n_cmp++; if (dcm_rst !== 1'b0) begin n_err++; $display("FAIL to_e135: got %b want 0", dcm_rst); end
    to_edge(136);
    n_cmp++; if (dcm_rst !== 1'b1 || lock_lost_cnt !== 8'd0) begin n_err++; $display("FAIL to_e136: got dcm=%b cnt=%0d want 1/0", dcm_rst, lock_lost_cnt); end
`else
    begin
      logic saw_high;
      saw_high = 1'b0;
      to_edge(4);
      while (ecount < 300) begin
        tick();
        if (dcm_rst !== 1'b0) saw_high = 1'b1;
      end
      n_cmp++; if (saw_high !== 1'b0) begin n_err++; $display("FAIL to_no_repulse: dcm_rst seen %b want 0 throughout", saw_high); end
      n_cmp++; if (RST !== 3'b111) begin n_err++; $display("FAIL to_RST_held: got %b want 111", RST); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_soft_reset();
    test_mid_release_reset();
    test_glitch_lock();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
